// File: rtl/mport_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// Word address = byte pointer bits [25:2]; MSB picks M9K vs SDRAM.
package mport_pkg;

  localparam int BYTE_ADDR_W = 26;
  localparam int WORD_OFS    = 2;
  localparam int CACHE_BITS  = 32;

  localparam int ADDR_W_DEF      = BYTE_ADDR_W - WORD_OFS;
  localparam int DATA_W_DEF      = CACHE_BITS;
  localparam int NUM_CLIENTS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DRAIN
  } arb_state_t;

  // Index width, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mport_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Ports: req vector, rr_last (last grantee) -> any, idx (next winner).
module rr_pick
  import mport_pkg::*;
#(
  parameter int N  = NUM_CLIENTS_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_last,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Scan from the farthest candidate back to rr_last+1 so the
  // closest requester after rr_last is the one that sticks.
  always_comb begin
    logic [IW-1:0] c;
    any = 1'b0;
    idx = '0;
    c   = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(rr_last) + k) % N);
      if (req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/mport_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one memory port.
// Ports: per-client cl_* requests in, mp_* to the port, cl_done/
// cl_data_load back to the grantee, grant_id/busy/proto_err status.
module mport_arbiter
  import mport_pkg::*;
#(
  parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  localparam int IW         = idx_w(NUM_CLIENTS)
) (
  input  logic                                clk,
  input  logic                                rst_l,
  input  logic [NUM_CLIENTS-1:0]              cl_r_en,
  input  logic [NUM_CLIENTS-1:0]              cl_w_en,
  input  logic [NUM_CLIENTS-1:0]              cl_write_through,
  input  logic [NUM_CLIENTS-1:0]              cl_read_through,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  cl_ptr,
  input  logic [NUM_CLIENTS-1:0][DATA_W-1:0]  cl_data_store,
  output logic [NUM_CLIENTS-1:0]              cl_done,
  output logic [DATA_W-1:0]                   cl_data_load,
  output logic                                mp_r_en,
  output logic                                mp_w_en,
  output logic                                mp_write_through,
  output logic                                mp_read_through,
  output logic [ADDR_W-1:0]                   mp_ptr,
  output logic [DATA_W-1:0]                   mp_data_store,
  input  logic [DATA_W-1:0]                   mp_data_load,
  input  logic                                mp_done,
  output logic [IW-1:0]                       grant_id,
  output logic                                busy,
  output logic                                proto_err
);

  arb_state_t           state;
  logic [IW-1:0]        rr_last;
  logic [NUM_CLIENTS-1:0] req;
  logic                 pick_any;
  logic [IW-1:0]        pick_idx;
  logic                 g_r;
  logic                 g_w;
  logic                 in_grant;

  assign req      = cl_r_en | cl_w_en;
  assign g_r      = cl_r_en[grant_id];
  assign g_w      = cl_w_en[grant_id];
  assign in_grant = (state == GRANT);

  rr_pick #(
    .N  (NUM_CLIENTS),
    .IW (IW)
  ) u_pick (
    .req     (req),
    .rr_last (rr_last),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      rr_last   <= IW'(NUM_CLIENTS - 1);
      grant_id  <= '0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            rr_last  <= pick_idx;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (g_r && g_w)
            proto_err <= 1'b1;
          // Release (or abandonment) ends the grant; the port
          // must still drop done before anyone else is served.
          if (!(g_r || g_w))
            state <= DRAIN;
        end
        DRAIN: begin
          if (!mp_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Passthrough of the grantee; everything is quiet outside GRANT.
  // A read+write request is forwarded as a write only.
  always_comb begin
    mp_r_en          = 1'b0;
    mp_w_en          = 1'b0;
    mp_write_through = 1'b0;
    mp_read_through  = 1'b0;
    mp_ptr           = '0;
    mp_data_store    = '0;
    cl_done          = '0;
    cl_data_load     = '0;
    if (in_grant) begin
      mp_w_en           = g_w;
      mp_r_en           = g_r & ~g_w;
      mp_write_through  = cl_write_through[grant_id];
      mp_read_through   = cl_read_through[grant_id];
      mp_ptr            = cl_ptr[grant_id];
      mp_data_store     = cl_data_store[grant_id];
      cl_done[grant_id] = mp_done;
      cl_data_load      = mp_data_load;
    end
  end

endmodule

// File: tb/tb_mport_arbiter.sv
// Randomized scoreboard bench for mport_arbiter.
// Clients and port are modelled at transaction level.
module tb_mport_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 32;

  typedef struct packed {
    logic          r;
    logic          w;
    logic          wt;
    logic          rt;
    logic [AW-1:0] ptr;
    logic [DW-1:0] data;
  } txn_t;

  logic                clk;
  logic                rst_l;
  logic [N-1:0]        cl_r_en;
  logic [N-1:0]        cl_w_en;
  logic [N-1:0]        cl_write_through;
  logic [N-1:0]        cl_read_through;
  logic [N-1:0][AW-1:0] cl_ptr;
  logic [N-1:0][DW-1:0] cl_data_store;
  logic [N-1:0]        cl_done;
  logic [DW-1:0]       cl_data_load;
  logic                mp_r_en;
  logic                mp_w_en;
  logic                mp_write_through;
  logic                mp_read_through;
  logic [AW-1:0]       mp_ptr;
  logic [DW-1:0]       mp_data_store;
  logic [DW-1:0]       mp_data_load;
  logic                mp_done;
  logic [1:0]          grant_id;
  logic                busy;
  logic                proto_err;

  mport_arbiter dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .cl_r_en          (cl_r_en),
    .cl_w_en          (cl_w_en),
    .cl_write_through (cl_write_through),
    .cl_read_through  (cl_read_through),
    .cl_ptr           (cl_ptr),
    .cl_data_store    (cl_data_store),
    .cl_done          (cl_done),
    .cl_data_load     (cl_data_load),
    .mp_r_en          (mp_r_en),
    .mp_w_en          (mp_w_en),
    .mp_write_through (mp_write_through),
    .mp_read_through  (mp_read_through),
    .mp_ptr           (mp_ptr),
    .mp_data_store    (mp_data_store),
    .mp_data_load     (mp_data_load),
    .mp_done          (mp_done),
    .grant_id         (grant_id),
    .busy             (busy),
    .proto_err        (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  txn_t exp_q[N][$];

  // samples taken by the monitor, consumed by the stimulus
  logic [N-1:0]  s_cl_done;
  logic          s_mp_en;
  logic [AW-1:0] s_mp_ptr;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] f_load(input logic [AW-1:0] p);
    return {p[7:0], p} ^ 32'hDEADBEEF;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int           m_last;
  int           m_win;
  bit           m_got;
  bit           exp_perr;
  bit           prev_busy;
  logic [N-1:0] prev_req;
  bit           prev_done;

  always @(negedge clk) begin
    int   w;
    int   c;
    txn_t t;
    logic [N-1:0] om;
    if (!rst_l) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
      m_last    = N - 1;
      m_win     = -1;
      m_got     = 1'b0;
      exp_perr  = 1'b0;
      prev_busy = 1'b0;
      prev_req  = '0;
      prev_done = 1'b0;
      s_cl_done = '0;
      s_mp_en   = 1'b0;
      s_mp_ptr  = '0;
    end else begin
      if (!prev_busy && busy) begin
        // winner: first requester after the previous grantee
        w = -1;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (w < 0 && prev_req[c]) w = c;
        end
        chk("grant_found", (w >= 0), 1);
        chk("drain_done_low", prev_done, 0);
        chk("perr_sticky", proto_err, exp_perr);
        if (w >= 0) begin
          chk("grant_id", grant_id, w);
          chk("grant_pending", (exp_q[w].size() != 0), 1);
          m_last = w;
          m_win  = w;
          m_got  = 1'b0;
          if (exp_q[w].size() != 0) begin
            t = exp_q[w][0];
            chk("mp_w_en", mp_w_en, t.w);
            chk("mp_r_en", mp_r_en, t.r & ~t.w);
            chk("mp_flags", {mp_write_through, mp_read_through},
                {t.wt, t.rt});
            chk("mp_ptr", mp_ptr, t.ptr);
            chk("mp_data_store", mp_data_store, t.data);
          end
        end
      end
      if (busy) begin
        om = '0;
        if (m_win >= 0) om[m_win] = 1'b1;
        chk("done_other", cl_done & ~om, 0);
        if (m_win >= 0 && !m_got && cl_done[m_win]) begin
          m_got = 1'b1;
          chk("done_has_txn", (exp_q[m_win].size() != 0), 1);
          if (exp_q[m_win].size() != 0) begin
            t = exp_q[m_win].pop_front();
            chk("cl_data_load", cl_data_load, f_load(t.ptr));
            exp_perr = exp_perr | (t.r & t.w);
            chk("proto_err", proto_err, exp_perr);
          end
        end
      end else begin
        chk("idle_quiet", {cl_done, mp_r_en, mp_w_en}, 0);
      end
      prev_busy = busy;
      prev_req  = cl_r_en | cl_w_en;
      prev_done = mp_done;
      s_cl_done = cl_done;
      s_mp_en   = mp_r_en | mp_w_en;
      s_mp_ptr  = mp_ptr;
    end
  end

  // ---------------- port and client models ----------------
  int           p_st;
  int           p_cnt;
  logic [AW-1:0] p_ptr;
  logic [N-1:0] c_act;
  bit           did_rst;
  int           rst_cnt;

  task automatic port_step();
    case (p_st)
      0: begin
        mp_data_load = $urandom;
        if (s_mp_en) begin
          p_ptr = s_mp_ptr;
          p_cnt = $urandom_range(0, 4);
          p_st  = 1;
        end
      end
      1: begin
        if (p_cnt == 0) begin
          mp_done      = 1'b1;
          mp_data_load = f_load(p_ptr);
          p_st         = 2;
        end else begin
          p_cnt--;
          mp_data_load = $urandom;
        end
      end
      2: begin
        if (!s_mp_en) begin
          p_cnt = $urandom_range(0, 3);
          mp_data_load = $urandom;
          if (p_cnt == 0) begin
            mp_done = 1'b0;
            p_st    = 0;
          end else begin
            p_st = 3;
          end
        end
      end
      default: begin
        p_cnt--;
        if (p_cnt <= 0) begin
          mp_done = 1'b0;
          p_st    = 0;
        end
      end
    endcase
  endtask

  task automatic client_step(input int cyc);
    int   prob;
    txn_t t;
    prob = (cyc < 2400) ? 40 : ((cyc < 3200) ? 100 : 0);
    for (int i = 0; i < N; i++) begin
      if (c_act[i]) begin
        if (s_cl_done[i]) begin
          cl_r_en[i] = 1'b0;
          cl_w_en[i] = 1'b0;
          c_act[i]   = 1'b0;
        end
      end else if (int'($urandom_range(0, 99)) < prob) begin
        t.ptr  = AW'($urandom);
        t.data = $urandom;
        t.wt   = 1'($urandom);
        t.rt   = 1'($urandom);
        t.w    = 1'($urandom);
        t.r    = ~t.w;
        if (cyc > 1500 && cyc < 2400 && $urandom_range(0, 24) == 0) begin
          t.r = 1'b1;
          t.w = 1'b1;
        end
        exp_q[i].push_back(t);
        cl_r_en[i]          = t.r;
        cl_w_en[i]          = t.w;
        cl_write_through[i] = t.wt;
        cl_read_through[i]  = t.rt;
        cl_ptr[i]           = t.ptr;
        cl_data_store[i]    = t.data;
        c_act[i]            = 1'b1;
      end else begin
        cl_ptr[i]        = AW'($urandom);
        cl_data_store[i] = $urandom;
      end
    end
  endtask

  task automatic clear_inputs();
    cl_r_en          = '0;
    cl_w_en          = '0;
    cl_write_through = '0;
    cl_read_through  = '0;
    cl_ptr           = '0;
    cl_data_store    = '0;
    mp_done          = 1'b0;
    mp_data_load     = '0;
    p_st             = 0;
    p_cnt            = 0;
    c_act            = '0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"}, {busy, proto_err}, 0);
    chk({nm, "_gid"}, grant_id, 0);
    chk({nm, "_mp_en"}, {mp_r_en, mp_w_en, mp_write_through,
                         mp_read_through}, 0);
    chk({nm, "_mp_ptr"}, mp_ptr, 0);
    chk({nm, "_mp_data"}, mp_data_store, 0);
    chk({nm, "_cl_done"}, cl_done, 0);
    chk({nm, "_cl_load"}, cl_data_load, 0);
  endtask

  initial begin
    int pend;
    rst_l   = 1'b0;
    did_rst = 1'b0;
    rst_cnt = 0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_l = 1'b1;
    for (int cyc = 0; cyc < 3600; cyc++) begin
      @(posedge clk);
      #1;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt != 0) continue;
        rst_l = 1'b1;
      end
      if (!did_rst && cyc >= 2500 && s_cl_done != 0 && mp_done) begin
        // async reset mid-grant while the port shows done
        #2;
        rst_l = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        clear_inputs();
        did_rst = 1'b1;
        rst_cnt = 2;
        continue;
      end
      if (cyc == 2700) chk("reset_trigger", did_rst, 1);
      port_step();
      client_step(cyc);
    end
    pend = 0;
    for (int i = 0; i < N; i++) pend += exp_q[i].size();
    chk("drained_queue", pend, 0);
    chk("drained_clients", c_act, 0);
    chk("final_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
